// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared lamp encodings, durations, TX state enum and ring helpers
package lamp_pkg;

  typedef enum logic [1:0] {
    C_OFF    = 2'd0,
    C_WHITE  = 2'd1,
    C_SUN    = 2'd2,
    C_YELLOW = 2'd3
  } color_e;

  localparam logic [3:0] LED_W = 4'b0011;
  localparam logic [3:0] LED_S = 4'b0110;
  localparam logic [3:0] LED_Y = 4'b1100;
  localparam logic [3:0] LED_N = 4'b0000;

  localparam int DUR_SHORT = 10000;
  localparam int DUR_LONG  = 100000;
  localparam int PHASE_W   = 20;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HIGH    = 2'd1,
    S_LOW     = 2'd2,
    S_OFFWAIT = 2'd3
  } tx_state_e;

  // Lit colors sit on a ring W=0, S=1, Y=2; OFF maps to 0 and is never stepped from.
  function automatic logic [1:0] color_to_ring(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [1:0] ring_to_color(input logic [1:0] r);
    return r + 2'd1;
  endfunction

  function automatic logic [1:0] ring_steps(input logic [1:0] from_c, input logic [1:0] to_c);
    logic [1:0] a;
    logic [1:0] b;
    a = color_to_ring(to_c);
    b = color_to_ring(from_c);
    return (a >= b) ? a - b : a + 2'd3 - b;
  endfunction

  function automatic logic [1:0] ring_next(input logic [1:0] c);
    logic [1:0] r;
    r = color_to_ring(c);
    return ring_to_color((r == 2'd2) ? 2'd0 : r + 2'd1);
  endfunction

endpackage

// File: rtl/lamp_switch_tx_phase_timer.sv
// rtl/lamp_switch_tx_phase_timer.sv - loadable 20-bit down-counter timing every TX phase
import lamp_pkg::*;

module phase_timer (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] value,
  output logic               expire
);

  logic [PHASE_W-1:0] cnt_q;

  // Counts down to 1 and parks there; expire marks the last cycle of a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q > 20'd1) begin
      cnt_q <= cnt_q - 20'd1;
    end
  end

  assign expire = (cnt_q == 20'd1);

endmodule

// File: rtl/lamp_switch_tx.sv
// rtl/lamp_switch_tx.sv - steps the open-loop lamp controller to a requested color via fake_switch
import lamp_pkg::*;

module lamp_switch_tx #(
  parameter int GAP_CYC        = 2,
  parameter int HOLD_CYC       = 2,
  parameter int OFF_WAIT_SHORT = 10004,
  parameter int OFF_WAIT_LONG  = 100004
) (
  input  logic       Div_CLK,
  input  logic       Sys_RST,
  input  logic       req,
  input  logic [1:0] target,
  input  logic       dur_sel,
  output logic       fake_switch,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_color
);

  tx_state_e          state_q, state_d;
  logic [1:0]         steps_q, steps_d;
  logic [1:0]         color_q, color_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tmr_load;
  logic [PHASE_W-1:0] tmr_val;
  logic               tmr_expire;

  phase_timer u_timer (
    .clk    (Div_CLK),
    .rst_n  (Sys_RST),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    color_d  = color_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 20'(HOLD_CYC);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (target == C_OFF) begin
            if (color_q == C_OFF) begin
              done_d = 1'b1;
            end else begin
              state_d  = S_OFFWAIT;
              tmr_load = 1'b1;
              tmr_val  = dur_sel ? 20'(OFF_WAIT_LONG) : 20'(OFF_WAIT_SHORT);
            end
          end else if (color_q == C_OFF) begin
            // The first high edge wakes the lamp into WHITE; remaining steps count from there.
            state_d  = S_HIGH;
            steps_d  = ring_steps(C_WHITE, target) + 2'd1;
            tmr_load = 1'b1;
            tmr_val  = 20'(HOLD_CYC);
          end else if (ring_steps(color_q, target) == 2'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_LOW;
            steps_d  = ring_steps(color_q, target);
            tmr_load = 1'b1;
            tmr_val  = 20'(GAP_CYC);
          end
        end
      end
      S_HIGH: begin
        if (tmr_expire) begin
          steps_d = steps_q - 2'd1;
          color_d = (color_q == C_OFF) ? C_WHITE : ring_next(color_q);
          if (steps_q == 2'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_LOW;
            tmr_load = 1'b1;
            tmr_val  = 20'(GAP_CYC);
          end
        end
      end
      S_LOW: begin
        if (tmr_expire) begin
          state_d  = S_HIGH;
          tmr_load = 1'b1;
          tmr_val  = 20'(HOLD_CYC);
        end
      end
      S_OFFWAIT: begin
        if (tmr_expire) begin
          state_d = S_IDLE;
          color_d = C_OFF;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fs_d   = fs_q;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_HIGH:            fs_d = 1'b1;
      S_LOW, S_OFFWAIT:  fs_d = 1'b0;
      default:           fs_d = fs_q;
    endcase
  end

  always_ff @(posedge Div_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q <= S_IDLE;
      steps_q <= 2'd0;
      color_q <= C_OFF;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      color_q <= color_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fake_switch = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_color   = color_q;

endmodule

// File: tb/tb_lamp_switch_tx.sv
// tb/tb_lamp_switch_tx.sv - directed self-checking bench for lamp_switch_tx
module tb_lamp_switch_tx;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [1:0] target;
  logic       dur_sel;
  logic       fake_switch;
  logic       busy;
  logic       done;
  logic [1:0] cur_color;

  int n_pass  = 0;
  int n_total = 0;

  lamp_switch_tx #(
    .GAP_CYC        (2),
    .HOLD_CYC       (2),
    .OFF_WAIT_SHORT (20),
    .OFF_WAIT_LONG  (30)
  ) dut (
    .Div_CLK     (clk),
    .Sys_RST     (rst_n),
    .req         (req),
    .target      (target),
    .dur_sel     (dur_sel),
    .fake_switch (fake_switch),
    .busy        (busy),
    .done        (done),
    .cur_color   (cur_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_fs"},    {31'd0, fake_switch}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},        32'd0);
    check({tag, "_done"},  {31'd0, done},        32'd0);
    check({tag, "_color"}, {30'd0, cur_color},   32'd0);
  endtask

  task automatic do_req(input logic [1:0] t, input logic d);
    @(negedge clk);
    req = 1'b1; target = t; dur_sel = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // Expects pat[0..n-1] on fake_switch over k+1..k+n with busy, then done at k+n+1.
  task automatic expect_wave(input string tag, input logic [31:0] pat, input int n,
                             input logic [1:0] col);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_fs%0d", tag, i + 1), {31'd0, fake_switch}, {31'd0, pat[i]});
      check($sformatf("%s_busy%0d", tag, i + 1), {31'd0, busy}, 32'd1);
      check($sformatf("%s_done%0d", tag, i + 1), {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"},  {31'd0, done},        32'd1);
    check({tag, "_busy"},  {31'd0, busy},        32'd0);
    check({tag, "_color"}, {30'd0, cur_color},   {30'd0, col});
    check({tag, "_fsend"}, {31'd0, fake_switch}, {31'd0, pat[n-1]});
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; target = 2'd0; dur_sel = 1'b0;
    #2;
    check_idle_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("idle");

    // OFF -> WHITE, then done must be a single-cycle pulse
    do_req(2'd1, 1'b0);
    expect_wave("off_w", 32'b11, 2, 2'd1);
    @(negedge clk);
    check("off_w_done_pulse", {31'd0, done}, 32'd0);
    check("off_w_fs_hold", {31'd0, fake_switch}, 32'd1);

    // WHITE -> WHITE no-op
    do_req(2'd1, 1'b0);
    @(negedge clk);
    check("noop_done", {31'd0, done}, 32'd1);
    check("noop_busy", {31'd0, busy}, 32'd0);
    check("noop_fs", {31'd0, fake_switch}, 32'd1);

    // WHITE -> YELLOW
    do_req(2'd3, 1'b0);
    expect_wave("w_y", 32'b11001100, 8, 2'd3);

    // YELLOW -> WHITE wraps in one step
    do_req(2'd1, 1'b0);
    expect_wave("y_w", 32'b1100, 4, 2'd1);

    // WHITE -> YELLOW with a stray req target=2 while busy
    do_req(2'd3, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("busyreq_fs%0d", i), {31'd0, fake_switch},
            {31'd0, ((i - 1) % 4) >= 2});
      if (i == 1) begin req = 1'b1; target = 2'd2; end
      if (i == 3) req = 1'b0;
    end
    @(negedge clk);
    check("busyreq_done", {31'd0, done}, 32'd1);
    check("busyreq_color", {30'd0, cur_color}, 32'd3);

    // Back-to-back: accept YELLOW -> OFF (short wait) on the edge done is visible
    req = 1'b1; target = 2'd0; dur_sel = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    expect_wave("y_off", 32'd0, 20, 2'd0);

    // OFF -> OFF no-op
    do_req(2'd0, 1'b1);
    @(negedge clk);
    check("offnoop_done", {31'd0, done}, 32'd1);
    check("offnoop_busy", {31'd0, busy}, 32'd0);

    // OFF -> SUN, then SUN -> OFF with the long wait
    do_req(2'd2, 1'b0);
    expect_wave("off_s", 32'b110011, 6, 2'd2);
    do_req(2'd0, 1'b1);
    expect_wave("s_off_long", 32'd0, 30, 2'd0);

    // Reset mid S_LOW of OFF -> SUN aborts asynchronously
    do_req(2'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_fs_low", {31'd0, fake_switch}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("post_abort");

    // Recovery from reset: OFF -> YELLOW
    do_req(2'd3, 1'b0);
    expect_wave("off_y", 32'b1100110011, 10, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
